fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Upstream neighbour of the instruction memory. Holds the program counter and
//  drives the memory address. Captures the combinational read data into a small
//  FIFO. Presents {instr, pc} to decode with a valid/ready handshake.
//  Handles decode stall (backpressure) and branch/jump redirect with flush.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset.
//  DEPTH     2              Fetch FIFO entries. Power of two, >=2.
//  PTR_W     1              log2(DEPTH). Must be consistent with DEPTH.
// PORTS
//  clk             in   1   System clock, rising edge.
//  rst             in   1   Asynchronous, active-high reset.
//  redirect_valid  in   1   Branch/jump taken this cycle.
//  redirect_pc     in   32  Target address. Bits [1:0] are ignored (forced 2'b00).
//  imem_addr       out  32  PC to instruction memory. Word index = addr[31:2].
//  imem_rdata      in   32  Same-cycle combinational read data.
//  instr_valid     out  1   FIFO head is valid.
//  instr           out  32  FIFO head instruction.
//  instr_pc        out  32  PC of the FIFO head.
//  instr_ready     in   1   Decode accepts the head this cycle.
//  fetch_count     out  32  Count of instructions pushed. Wraps modulo 2^32.
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc=RESET_PC, FIFO empty, instr_valid=0, instr=0, instr_pc=0, fetch_count=0.
//   - FSM enters WARM.
//  FSM:
//   - WARM: no push for exactly one cycle after rst deasserts, because the
//     memory output is zeroed during reset. Always -> RUN.
//   - RUN: normal operation. Stays in RUN until rst.
//  imem_addr = pc, combinational from the pc register.
//  pop  = instr_valid & instr_ready.
//  push = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
//  On push: FIFO[wr] <= {imem_rdata, pc}; pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0);
//   fetch_count++.
//  Latency: a word fetched at edge N appears at instr_valid in cycle N+1.
//   With instr_ready held high, throughput is 1 instr/cycle.
//  Full FIFO with no pop: no push; pc holds; imem_addr is stable.
//  Full FIFO with pop: push and pop occur in the same cycle; count is unchanged.
//  Empty FIFO: instr_valid=0; instr and instr_pc hold their last values.
//   instr_ready is ignored.
//  Redirect (highest priority):
//   - pc <= {redirect_pc[31:2],2'b00}.
//   - FIFO flushed: rd=wr=count=0. Any concurrent pop still counts as consumed.
//   - No push that cycle.
//   - The target word appears at instr_valid 2 cycles after the redirect edge.
//  Redirect during WARM: pc is updated and the FSM still moves to RUN.
//  Reset mid-operation: everything returns to reset values immediately
//   (async); FIFO contents are discarded.
//  count is PTR_W+1 bits wide. rd/wr are PTR_W-bit pointers that wrap naturally.
// STRUCTURE
//  rv_fetch_pkg: RESET_PC default, fetch_state_e {WARM,RUN}, PC_INC=32'd4.
//  Sub-module fetch_fifo (DEPTH x 64b, push/pop/flush, count, full/empty).
//  The top level holds the pc register, the FSM, push/pop logic and fetch_count.
// TESTING
//  1. Reset release, imem[0..3]=A,B,C,D, ready=1
//     -> instr_valid rises 2 cycles after release; A@0, B@4, C@8, D@12 on
//        consecutive cycles.
//  2. ready=0 for 5 cycles after the first valid
//     -> count reaches 2; imem_addr frozen at 8; A held at the head; no loss on resume.
//  3. redirect_valid with redirect_pc=32'h40, FIFO full
//     -> instr_valid=0 the next cycle; instr_pc=32'h40 two cycles after the redirect.
//  4. redirect_pc=32'h43 -> fetch from 32'h40.
//     pc=32'hFFFF_FFFC push -> next pc=0.
//  5. rst asserted mid-stream with 2 entries buffered
//     -> instr_valid=0, fetch_count=0, imem_addr=RESET_PC in the same cycle.
//  6. Full FIFO with ready=1 and a same-cycle pop+push
//     -> count stays 2; fetch_count increments by 1 per cycle.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package rv_fetch_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'd4;

   typedef enum logic {WARM, RUN} fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch FIFO of {instr, pc} entries: head visible the cycle after push, push+pop when full.
// Flush clears pointers; when empty the output holds the last head presented.
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic        flush_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] rdata_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [63:0]      mem_q [DEPTH];
   logic [63:0]      hold_q;
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign rdata_o = empty_o ? hold_q : mem_q[rd_q];

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + 1'b1;
         if (pop_i)  rd_d = rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         hold_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
         // Remember the current head so an emptied FIFO keeps showing it.
         if (!empty_o) hold_q <= mem_q[rd_q];
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, one-cycle warm-up FSM, fetch FIFO; word appears one cycle after its push.
// Decode stall freezes the PC once the FIFO is full; redirect flushes and wins over everything.
module fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2,
   parameter int          PTR_W    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic [31:0] fetch_count
);
   fetch_state_e state_q, state_d;
   logic         run_en;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fetch_count_q, fetch_count_d;
   logic         push, pop, fifo_full, fifo_empty;
   fetch_entry_t wr_entry, rd_entry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= WARM;
      else     state_q <= state_d;
   end

   // Memory data is zeroed during reset, so the first cycle after release never pushes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WARM:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = WARM;
      endcase
   end

   always_comb begin
      run_en = 1'b0;
      if (state_q == RUN) run_en = 1'b1;
   end

   assign instr_valid = ~fifo_empty;
   assign pop         = instr_valid & instr_ready;
   assign push        = run_en & ~redirect_valid & (~fifo_full | pop);

   always_comb begin
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
      if (redirect_valid)  pc_d = {redirect_pc[31:2], 2'b00};
      else if (push)       pc_d = pc_q + PC_INC;
      if (push)            fetch_count_d = fetch_count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr      = pc_q;
   assign fetch_count    = fetch_count_q;
   assign wr_entry.instr = imem_rdata;
   assign wr_entry.pc    = pc_q;
   assign instr          = rd_entry.instr;
   assign instr_pc       = rd_entry.pc;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wdata_i (wr_entry),
      .rdata_o (rd_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns 0x1000_0000 | word index.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata = rst ? 32'h0 : (32'h1000_0000 | {26'b0, imem_addr[7:2]});

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .fetch_count    (fetch_count)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h1000_0000 | {26'b0, a[7:2]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset held over one edge, released 1ns after an edge; the next edge is the WARM edge.
   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = rdy;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      step();
      step();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_fetch_count got %0d exp 0", fetch_count); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr got %h exp 0", imem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] p;
      do_reset(1'b1);
      step();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL warm_no_push got %0b exp 0", instr_valid); end
      for (int k = 0; k < 4; k++) begin
         step();
         p = 32'(k * 4);
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp 1", k, instr_valid); end
         checks++; if (instr !== word_at(p)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", k, instr, word_at(p)); end
         checks++; if (instr_pc !== p) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, instr_pc, p); end
      end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL stream_fetch_count got %0d exp 4", fetch_count); end
   endtask

   task automatic test_stall();
      logic [31:0] p;
      do_reset(1'b0);
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (instr !== word_at(32'h0) || instr_pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d] got %h@%h exp %h@0", k, instr, instr_pc, word_at(32'h0)); end
         checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 8", k, imem_addr); end
      end
      checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_fetch_count got %0d exp 2", fetch_count); end
      instr_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         step();
         p = 32'(k * 4);
         checks++; if (instr_valid !== 1'b1 || instr_pc !== p || instr !== word_at(p)) begin errors++; $display("FAIL resume[%0d] got v=%0b %h@%h exp %h@%h", k, instr_valid, instr, instr_pc, word_at(p), p); end
      end
   endtask

   task automatic test_redirect_full();
      do_reset(1'b0);
      step();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %0b exp 0", instr_valid); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL redir_hold_pc got %h exp 0", instr_pc); end
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== word_at(32'h40)) begin errors++; $display("FAIL redir_target got v=%0b %h@%h exp %h@40", instr_valid, instr, instr_pc, word_at(32'h40)); end
      checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_fetch_count got %0d exp 3", fetch_count); end
   endtask

   task automatic test_align_wrap();
      rst = 1'b1;
      instr_ready = 1'b1;
      step();
      rst = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h23;
      step();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'h20 || instr_valid !== 1'b0) begin errors++; $display("FAIL warm_redir got addr=%h v=%0b exp addr=20 v=0", imem_addr, instr_valid); end
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin errors++; $display("FAIL warm_redir_push got v=%0b pc=%h exp v=1 pc=20", instr_valid, instr_pc); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h43;
      step();
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL align_addr got %h exp 40", imem_addr); end
      redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h exp fffffffc", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", imem_addr); end
      checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== word_at(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_head got %h@%h exp %h@fffffffc", instr, instr_pc, word_at(32'hFFFF_FFFC)); end
      step();
      checks++; if (instr_pc !== 32'h0 || instr !== word_at(32'h0)) begin errors++; $display("FAIL wrap_after got %h@%h exp %h@0", instr, instr_pc, word_at(32'h0)); end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0);
      step();
      step();
      step();
      checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL pre_rst_count got %0d exp 2", fetch_count); end
      rst = 1'b1;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b exp 0", instr_valid); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", fetch_count); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_addr got %h exp 0", imem_addr); end
      checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_head got %h@%h exp 0@0", instr, instr_pc); end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0);
      step();
      step();
      step();
      instr_ready = 1'b1;
      step();
      checks++; if (fetch_count !== 32'd3 || instr_pc !== 32'h4) begin errors++; $display("FAIL b2b_1 got cnt=%0d pc=%h exp cnt=3 pc=4", fetch_count, instr_pc); end
      step();
      checks++; if (fetch_count !== 32'd4 || instr_pc !== 32'h8) begin errors++; $display("FAIL b2b_2 got cnt=%0d pc=%h exp cnt=4 pc=8", fetch_count, instr_pc); end
      instr_ready = 1'b0;
      step();
      checks++; if (fetch_count !== 32'd4 || imem_addr !== 32'h10) begin errors++; $display("FAIL b2b_full got cnt=%0d addr=%h exp cnt=4 addr=10", fetch_count, imem_addr); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin errors++; $display("FAIL b2b_head got v=%0b pc=%h exp v=1 pc=8", instr_valid, instr_pc); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_align_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
